// File: rtl/ccff_frame_loader.sv
// Configuration-chain loader: takes words over a valid/ready stream and shifts them MSB-first
// into the fabric's ccff_head, one bit per prog_clk, for exactly CHAIN_LEN bits.
module ccff_frame_loader #(
    parameter int unsigned CHAIN_LEN = 64,
    parameter int unsigned WORD_W    = 8,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                             prog_clk,
    input  logic                             prog_rst_n,
    input  logic                             start,
    input  logic                             abort,
    input  logic [WORD_W-1:0]                s_data,
    input  logic                             s_valid,
    output logic                             s_ready,
    output logic                             ccff_head,
    output logic                             ccff_shift_en,
    output logic                             busy,
    output logic                             done,
    output logic                             err,
    output logic [$clog2(CHAIN_LEN+1)-1:0]   bit_cnt
);

    localparam int unsigned CntW = $clog2(CHAIN_LEN + 1);
    localparam int unsigned NbW  = $clog2(WORD_W + 1);
    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StWait, StShift} state_e;

    state_e            state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [NbW-1:0]    nb_q, nb_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              s_ready_q, s_ready_d;
    logic              head_q, head_d;
    logic              shift_en_q, shift_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [CntW-1:0]   remaining;
    logic [NbW-1:0]    word_nb;

    // Bits this word will contribute: a short tail word only shifts its top bits.
    always_comb begin
        remaining = CntW'(CHAIN_LEN) - cnt_q;
        word_nb   = (32'(remaining) < WORD_W) ? NbW'(remaining) : NbW'(WORD_W);
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        nb_d    = nb_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StWait;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    tmo_d   = '0;
                end
            end
            StWait: begin
                if (s_valid) begin
                    shreg_d = s_data;
                    nb_d    = word_nb;
                    tmo_d   = '0;
                    state_d = StShift;
                end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            StShift: begin
                shreg_d = shreg_q << 1;
                nb_d    = nb_q - NbW'(1);
                if (cnt_q != CntW'(CHAIN_LEN)) begin
                    cnt_d = cnt_q + CntW'(1);
                end
                if (nb_q == NbW'(1)) begin
                    if (cnt_d == CntW'(CHAIN_LEN)) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort overrides everything, including a start seen in the same cycle.
        if (abort) begin
            state_d = StIdle;
            done_d  = 1'b0;
            err_d   = err_q;
            cnt_d   = cnt_q;
            tmo_d   = tmo_q;
        end

        // Outputs are registered from the next state so they line up with the state.
        s_ready_d  = (state_d == StWait);
        shift_en_d = (state_d == StShift);
        busy_d     = (state_d != StIdle);
        head_d     = (state_d == StShift) ? shreg_d[WORD_W-1] : head_q;
    end

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            state_q    <= StIdle;
            shreg_q    <= '0;
            nb_q       <= '0;
            tmo_q      <= '0;
            cnt_q      <= '0;
            s_ready_q  <= 1'b0;
            head_q     <= 1'b0;
            shift_en_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            nb_q       <= nb_d;
            tmo_q      <= tmo_d;
            cnt_q      <= cnt_d;
            s_ready_q  <= s_ready_d;
            head_q     <= head_d;
            shift_en_q <= shift_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign s_ready       = s_ready_q;
    assign ccff_head     = head_q;
    assign ccff_shift_en = shift_en_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign bit_cnt       = cnt_q;

endmodule
